// File: rtl/fifo_32o_16_unpack.sv
// Unpacks 32-bit words from a first-word-fall-through FIFO into a 16-bit pixel stream with frame
// markers. Optional stall counter enabled by defining UNPACK_UNDERRUN_CNT_EN.
module fifo_32o_16_unpack #(
  parameter int unsigned H_ACTIVE  = 1920,
  parameter int unsigned V_ACTIVE  = 1080,
  parameter int unsigned CNT_W     = 12,
  parameter bit          LOW_FIRST = 1'b1
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        fifo_rd_vld,
  input  logic [31:0] fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        pix_vld,
  output logic [15:0] pix_data,
  input  logic        pix_rdy,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [15:0] underrun_cnt
);

  typedef enum logic [1:0] {StEmpty, StFirst, StSecond} state_e;

  localparam logic [CNT_W-1:0] HLast = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VLast = CNT_W'(V_ACTIVE - 1);

  state_e           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]      first_half, second_half;
  logic             xfer, h_last, v_last;

  assign fifo_rd_en = fifo_rd_vld & ~rd_rst &
                      ((state_q == StEmpty) | ((state_q == StSecond) & pix_rdy));

  assign pix_vld = (state_q != StEmpty);
  assign xfer    = pix_vld & pix_rdy;

  assign first_half  = LOW_FIRST ? word_q[15:0]  : word_q[31:16];
  assign second_half = LOW_FIRST ? word_q[31:16] : word_q[15:0];
  assign pix_data    = (state_q == StSecond) ? second_half : first_half;

  assign h_last  = (h_cnt_q == HLast);
  assign v_last  = (v_cnt_q == VLast);
  assign pix_sof = pix_vld & (h_cnt_q == '0) & (v_cnt_q == '0);
  assign pix_eol = pix_vld & h_last;
  assign pix_eof = pix_vld & h_last & v_last;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    if (fifo_rd_en) begin
      // A pop in SECOND overlaps the last transfer of the old word, so no bubble.
      word_d  = fifo_rd_data;
      state_d = StFirst;
    end else if (pix_rdy) begin
      case (state_q)
        StFirst:  state_d = StSecond;
        StSecond: state_d = StEmpty;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (xfer) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= StEmpty;
      word_q  <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

`ifdef UNPACK_UNDERRUN_CNT_EN
  logic        started_q;
  logic [15:0] underrun_q;

  // Idle cycles before the first transfer are start-up latency, not stalls.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      started_q  <= 1'b0;
      underrun_q <= '0;
    end else begin
      if (xfer) begin
        started_q <= 1'b1;
      end
      if (started_q & pix_rdy & ~pix_vld & (underrun_q != 16'hFFFF)) begin
        underrun_q <= underrun_q + 16'd1;
      end
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_32o_16_unpack.sv
// Scoreboard bench for fifo_32o_16_unpack: a queue-based FIFO model feeds the DUT, popped words
// become expected pixels indexed by position in the frame, and a monitor checks every transfer.
module tb_fifo_32o_16_unpack;

  localparam int unsigned H = 4;
  localparam int unsigned V = 2;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        fifo_rd_vld;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        pix_vld;
  logic [15:0] pix_data;
  logic        pix_rdy;
  logic        pix_sof, pix_eol, pix_eof;
  logic [15:0] underrun_cnt;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fifo_q[$];
  pix_t        exp_q[$];
  int unsigned pix_idx = 0;
  bit          gate;

  // Snapshot of DUT outputs taken mid-cycle by step().
  logic        s_en, s_vld, s_sof, s_eol, s_eof;
  logic [15:0] s_data, s_under;

  fifo_32o_16_unpack #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .CNT_W    (4),
    .LOW_FIRST(1'b1)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .fifo_rd_vld (fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .pix_vld     (pix_vld),
    .pix_data    (pix_data),
    .pix_rdy     (pix_rdy),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .underrun_cnt(underrun_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected markers follow purely from the pixel's position in the frame.
  function automatic void push_pix(input logic [15:0] d);
    pix_t        p;
    int unsigned f;
    f      = pix_idx % (H * V);
    p.data = d;
    p.sof  = (f == 0);
    p.eol  = ((f % H) == H - 1);
    p.eof  = (f == H * V - 1);
    exp_q.push_back(p);
    pix_idx++;
  endfunction

  task automatic present();
    fifo_rd_vld  = gate && (fifo_q.size() > 0);
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
  endtask

  // One clock: drive inputs, snapshot outputs on the falling edge, apply the pop at the rising edge.
  task automatic step();
    logic        pop;
    logic [31:0] w;
    present();
    @(negedge rd_clk);
    s_en    = fifo_rd_en;
    s_vld   = pix_vld;
    s_data  = pix_data;
    s_sof   = pix_sof;
    s_eol   = pix_eol;
    s_eof   = pix_eof;
    s_under = underrun_cnt;
    pop     = fifo_rd_en;
    @(posedge rd_clk);
    if (rd_rst) begin
      exp_q.delete();
      pix_idx = 0;
    end else if (pop) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got fifo_rd_en=1, expected 0 with FIFO empty");
      end else begin
        w = fifo_q.pop_front();
        push_pix(w[15:0]);
        push_pix(w[31:16]);
      end
    end
    #1;
  endtask

  // Monitor: scoreboard on every transfer, plus stall stability and idle marker checks.
  initial begin
    logic        hold;
    logic [15:0] hold_data;
    pix_t        e;
    hold      = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge rd_clk);
      if (rd_rst !== 1'b0) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("stall_vld", pix_vld, 1);
          chk("stall_data", pix_data, hold_data);
        end
        if (!pix_vld) chk("idle_markers", {pix_sof, pix_eol, pix_eof}, 0);
        if (pix_vld && pix_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got %h, expected no transfer", pix_data);
          end else begin
            e = exp_q.pop_front();
            chk("pix_data", pix_data, e.data);
            chk("pix_markers", {pix_sof, pix_eol, pix_eof}, {e.sof, e.eol, e.eof});
          end
        end
`ifndef UNPACK_UNDERRUN_CNT_EN
        chk("underrun_tied", underrun_cnt, 0);
`endif
        hold      = pix_vld && !pix_rdy;
        hold_data = pix_data;
      end
    end
  end

  initial begin
    logic [15:0] st_data[5];
    logic        st_en[5];
    logic        st_vld[5];
    logic        st_sof[5];
    logic [31:0] wd;
    logic [31:0] words[4];
    int          n;

    st_data = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    st_en   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    st_vld  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    st_sof  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset with data waiting, then stream two words.
    rd_rst  = 1'b1;
    pix_rdy = 1'b1;
    gate    = 1'b1;
    fifo_q.push_back(32'h2222_1111);
    fifo_q.push_back(32'h4444_3333);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rd_en", s_en, 0);
      chk("rst_vld", s_vld, 0);
      chk("rst_markers", {s_sof, s_eol, s_eof}, 0);
      chk("rst_data", s_data, 0);
      chk("rst_underrun", s_under, 0);
    end
    rd_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stream_rd_en", s_en, st_en[c]);
      chk("stream_vld", s_vld, st_vld[c]);
      chk("stream_data", s_data, st_data[c]);
      chk("stream_sof", s_sof, st_sof[c]);
    end

    // Backpressure while the second half is showing.
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    fifo_q.push_back(32'h2222_1111);
    fifo_q.push_back(32'h4444_3333);
    step();
    chk("bp_pop", s_en, 1);
    step();
    chk("bp_first", s_data, 16'h1111);
    pix_rdy = 1'b0;
    repeat (5) begin
      step();
      chk("bp_hold_data", s_data, 16'h2222);
      chk("bp_hold_vld", s_vld, 1);
      chk("bp_hold_rd_en", s_en, 0);
    end
    pix_rdy = 1'b1;
    step();
    chk("bp_release_data", s_data, 16'h2222);
    chk("bp_release_rd_en", s_en, 1);
    step();
    chk("bp_next_data", s_data, 16'h3333);
    step();
    chk("bp_last_data", s_data, 16'h4444);

    // Continuous data across a frame and a half: markers come from the scoreboard.
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    repeat (6) fifo_q.push_back($urandom);
    repeat (14) step();

    // Ten stall cycles mid-frame.
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    fifo_q.push_back(32'hBBBB_AAAA);
    repeat (12) step();
    fifo_q.push_back(32'hDDDD_CCCC);
    step();
    chk("ur_pop", s_en, 1);
    step();
    chk("ur_vld", s_vld, 1);
`ifdef UNPACK_UNDERRUN_CNT_EN
    chk("underrun_cnt", s_under, 10);
`else
    chk("underrun_cnt", s_under, 0);
`endif
    step();

    // Reset while the first half of the third word is showing.
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      fifo_q.push_back(words[i]);
    end
    repeat (5) step();
    rd_rst  = 1'b1;
    pix_rdy = 1'b0;
    step();
    chk("mfr_showing_px4", s_data, {16'h0, words[2][15:0]});
    rd_rst  = 1'b0;
    pix_rdy = 1'b1;
    step();
    chk("mfr_pop", s_en, 1);
    step();
    chk("mfr_vld", s_vld, 1);
    chk("mfr_data", s_data, {16'h0, words[3][15:0]});
    chk("mfr_sof", s_sof, 1);
    step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      gate    = ($urandom_range(0, 3) != 0);
      pix_rdy = ($urandom_range(0, 3) != 0);
      rd_rst  = ($urandom_range(0, 499) == 0);
      if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) begin
        wd = $urandom;
        fifo_q.push_back(wd);
      end
      step();
    end

    rd_rst  = 1'b0;
    gate    = 1'b1;
    pix_rdy = 1'b1;
    n       = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size() + fifo_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
